user_obi_demux_ctrl: RTL and testbench

Parametrised successor to the fixed user-domain subordinate demux. Routes one OBI subordinate port to NumMgrPorts downstream subordinates and tracks outstanding transactions so responses return in order. Integrates a built-in error responder for undecoded addresses and raises an interrupt on each decode error. Sits between the croc user-subordinate port and the user peripherals (ROM, FFT, future blocks).

---
 rtl/user_obi_demux_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_user_obi_demux_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/user_obi_demux_ctrl.sv
// OBI user-domain demux: in-order tracking, error responder, decode-error irq.
// Optional watchdog drain: define USER_OBI_DEMUX_TIMEOUT_EN.

package user_obi_pkg;
  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;
  localparam int unsigned IdW   = 4;

  typedef struct packed {
    logic [AddrW-1:0]   addr;
    logic               we;
    logic [DataW/8-1:0] be;
    logic [DataW-1:0]   wdata;
    logic [IdW-1:0]     aid;
  } user_obi_a_t;

  typedef struct packed {
    logic        req;
    user_obi_a_t a;
  } user_obi_req_t;

  typedef struct packed {
    logic [DataW-1:0] rdata;
    logic [IdW-1:0]   rid;
    logic             err;
  } user_obi_r_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    user_obi_r_t r;
  } user_obi_rsp_t;
endpackage

module user_obi_demux_ctrl
  import user_obi_pkg::*;
#(
  parameter type         sbr_obi_req_t = user_obi_req_t,
  parameter type         sbr_obi_rsp_t = user_obi_rsp_t,
  parameter type         obi_req_t     = user_obi_req_t,
  parameter type         obi_rsp_t     = user_obi_rsp_t,
  parameter int unsigned NumMgrPorts   = 3,
  parameter int unsigned NumMaxTrans   = 2,
  parameter logic [31:0] RspData       = 32'hBADCAB1E,
`ifdef USER_OBI_DEMUX_TIMEOUT_EN
  parameter int unsigned TimeoutCycles = 1024,
`endif
  localparam int unsigned SelW =
    (NumMgrPorts > 1) ? $clog2(NumMgrPorts) : 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [SelW-1:0] sbr_port_select_i,
  input  logic         dec_valid_i,
  input  sbr_obi_req_t sbr_port_req_i,
  output sbr_obi_rsp_t sbr_port_rsp_o,
  output obi_req_t     mgr_ports_req_o [NumMgrPorts],
  input  obi_rsp_t     mgr_ports_rsp_i [NumMgrPorts],
  output logic         busy_o,
  output logic         dec_err_irq_o,
  output logic         stray_rsp_o,
`ifdef USER_OBI_DEMUX_TIMEOUT_EN
  output logic         timeout_o,
`endif
  input  logic         clr_i
);

  localparam int unsigned TgtW = $clog2(NumMgrPorts + 1);
  localparam int unsigned CntW = $clog2(NumMaxTrans + 1);
  localparam logic [TgtW-1:0] ErrTgt = TgtW'(NumMgrPorts);
  localparam logic [CntW-1:0] CntMax = CntW'(NumMaxTrans);

  logic [TgtW-1:0] tgt, cur_q;
  logic [CntW-1:0] cnt_q;
  logic            err_rvalid_q;
  logic [IdW-1:0]  err_rid_q;
  logic tgt_gnt, allowed, gnt, accept, err_acc;
  logic cur_rvalid, cur_drop, other_rvalid;
  logic rsp_ok, cnt_dec, stray_set;
  logic drain_q;
  logic [NumMgrPorts-1:0] drop_mask;
  obi_rsp_t cur_rsp;

  // Out-of-range selects fall through to the error responder.
  always_comb begin
    tgt = ErrTgt;
    if (dec_valid_i && (TgtW'(sbr_port_select_i) < ErrTgt))
      tgt = TgtW'(sbr_port_select_i);
  end

  always_comb begin
    tgt_gnt         = 1'b1;
    cur_rsp         = '0;
    cur_rsp.rvalid  = err_rvalid_q;
    cur_rsp.r.rdata = RspData;
    cur_rsp.r.err   = 1'b1;
    cur_rsp.r.rid   = err_rid_q;
    cur_drop        = 1'b0;
    other_rvalid    = 1'b0;
    for (int i = 0; i < NumMgrPorts; i++) begin
      if (tgt == TgtW'(i))
        tgt_gnt = mgr_ports_rsp_i[i].gnt;
      if (cur_q == TgtW'(i)) begin
        cur_rsp  = mgr_ports_rsp_i[i];
        cur_drop = drop_mask[i];
      end else begin
        other_rvalid |= mgr_ports_rsp_i[i].rvalid
                      & ~drop_mask[i];
      end
    end
    cur_rvalid = cur_rsp.rvalid & ~cur_drop;
  end

  assign allowed = ~drain_q
                 & ((cnt_q == '0)
                 | ((tgt == cur_q) & (cnt_q < CntMax)));
  assign gnt       = allowed & tgt_gnt;
  assign accept    = sbr_port_req_i.req & gnt;
  assign err_acc   = accept & (tgt == ErrTgt);
  assign rsp_ok    = cur_rvalid & (cnt_q != '0) & ~drain_q;
  assign cnt_dec   = rsp_ok | drain_q;
  assign stray_set = other_rvalid
                   | (cur_rvalid & ((cnt_q == '0) | drain_q));
  assign busy_o    = (cnt_q != '0);

  always_comb begin
    for (int i = 0; i < NumMgrPorts; i++) begin
      mgr_ports_req_o[i]     = '0;
      mgr_ports_req_o[i].a   = sbr_port_req_i.a;
      mgr_ports_req_o[i].req = sbr_port_req_i.req & allowed
                             & (tgt == TgtW'(i));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q         <= '0;
      cur_q         <= '0;
      err_rvalid_q  <= 1'b0;
      err_rid_q     <= '0;
      dec_err_irq_o <= 1'b0;
      stray_rsp_o   <= 1'b0;
    end else begin
      err_rvalid_q  <= err_acc;
      dec_err_irq_o <= err_acc;
      if (err_acc)
        err_rid_q <= sbr_port_req_i.a.aid;
      if (accept)
        cur_q <= tgt;
      unique case (1'b1)
        accept & ~cnt_dec: cnt_q <= cnt_q + 1'b1;
        ~accept & cnt_dec: cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
      if (stray_set)
        stray_rsp_o <= 1'b1;
      else if (clr_i)
        stray_rsp_o <= 1'b0;
    end
  end

`ifdef USER_OBI_DEMUX_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TimeoutCycles + 1);
  localparam logic [WdW-1:0] WdMax = WdW'(TimeoutCycles);

  logic [WdW-1:0]  wd_q;
  logic [CntW-1:0] drop_cnt_q;
  logic [TgtW-1:0] drop_port_q;
  logic [IdW-1:0]  last_aid_q;
  logic to_fire, drop_vld;

  assign to_fire = ~drain_q & (cnt_q != '0)
                 & (cur_q != ErrTgt) & ~cur_rvalid
                 & (wd_q == WdMax);

  // Late answers from a timed-out port are swallowed, one per drained beat.
  always_comb begin
    drop_mask = '0;
    drop_vld  = 1'b0;
    for (int i = 0; i < NumMgrPorts; i++) begin
      if ((drop_cnt_q != '0) && (drop_port_q == TgtW'(i))) begin
        drop_mask[i] = 1'b1;
        drop_vld     = mgr_ports_rsp_i[i].rvalid;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_q        <= '0;
      drain_q     <= 1'b0;
      drop_cnt_q  <= '0;
      drop_port_q <= '0;
      last_aid_q  <= '0;
      timeout_o   <= 1'b0;
    end else begin
      if (accept)
        last_aid_q <= sbr_port_req_i.a.aid;
      if ((cnt_q == '0) || drain_q || rsp_ok || to_fire)
        wd_q <= '0;
      else if (wd_q != WdMax)
        wd_q <= wd_q + 1'b1;
      if (to_fire) begin
        drain_q     <= 1'b1;
        drop_cnt_q  <= cnt_q;
        drop_port_q <= cur_q;
      end else begin
        if (drain_q && (cnt_q == CntW'(1)))
          drain_q <= 1'b0;
        if (drop_vld)
          drop_cnt_q <= drop_cnt_q - 1'b1;
      end
      if (to_fire)
        timeout_o <= 1'b1;
      else if (clr_i)
        timeout_o <= 1'b0;
    end
  end

  always_comb begin
    sbr_port_rsp_o        = '0;
    sbr_port_rsp_o.gnt    = gnt;
    sbr_port_rsp_o.rvalid = rsp_ok;
    sbr_port_rsp_o.r      = cur_rsp.r;
    if (drain_q) begin
      sbr_port_rsp_o.rvalid  = 1'b1;
      sbr_port_rsp_o.r.rdata = RspData;
      sbr_port_rsp_o.r.err   = 1'b1;
      sbr_port_rsp_o.r.rid   = last_aid_q;
    end
  end
`else
  assign drain_q   = 1'b0;
  assign drop_mask = '0;

  always_comb begin
    sbr_port_rsp_o        = '0;
    sbr_port_rsp_o.gnt    = gnt;
    sbr_port_rsp_o.rvalid = rsp_ok;
    sbr_port_rsp_o.r      = cur_rsp.r;
  end
`endif

endmodule

// File: tb/tb_user_obi_demux_ctrl.sv
// Bench for user_obi_demux_ctrl: routing table plus scoreboarded sequences.
// Watchdog sequence compiled only with USER_OBI_DEMUX_TIMEOUT_EN.

module tb_user_obi_demux_ctrl;
  import user_obi_pkg::*;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] sel;
  logic dec_valid, clr;
  logic busy, irq, stray;
  user_obi_req_t req;
  user_obi_rsp_t rsp;
  user_obi_req_t mreq [N];
  user_obi_rsp_t mrsp [N];
`ifdef USER_OBI_DEMUX_TIMEOUT_EN
  logic to;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct packed {
    logic [31:0]    rdata;
    logic           err;
    logic [IdW-1:0] rid;
  } exp_t;
  exp_t sb [$];

  typedef struct packed {
    logic       dv;
    logic [1:0] sel;
    logic       rq;
    logic [2:0] dg;
    logic [2:0] ereq;
    logic       egnt;
  } vec_t;
  vec_t tab [7];

  always #5 clk = ~clk;

  user_obi_demux_ctrl #(
    .NumMgrPorts(N),
    .NumMaxTrans(2)
`ifdef USER_OBI_DEMUX_TIMEOUT_EN
    , .TimeoutCycles(16)
`endif
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .sbr_port_select_i(sel),
    .dec_valid_i      (dec_valid),
    .sbr_port_req_i   (req),
    .sbr_port_rsp_o   (rsp),
    .mgr_ports_req_o  (mreq),
    .mgr_ports_rsp_i  (mrsp),
    .busy_o           (busy),
    .dec_err_irq_o    (irq),
    .stray_rsp_o      (stray),
`ifdef USER_OBI_DEMUX_TIMEOUT_EN
    .timeout_o        (to),
`endif
    .clr_i            (clr)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic idle();
    req       = '0;
    dec_valid = 1'b1;
    sel       = 2'd0;
    clr       = 1'b0;
    for (int i = 0; i < N; i++) mrsp[i] = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic rd(input logic dv, input logic [1:0] s,
                    input logic [3:0] aid);
    req.req    = 1'b1;
    req.a.addr = 32'h1000 + {28'h0, aid};
    req.a.aid  = aid;
    dec_valid  = dv;
    sel        = s;
  endtask

  task automatic rv(input int p, input logic [31:0] d,
                    input logic [3:0] id);
    mrsp[p].rvalid  = 1'b1;
    mrsp[p].r.rdata = d;
    mrsp[p].r.rid   = id;
  endtask

  task automatic push(input logic [31:0] d, input logic e,
                      input logic [3:0] id);
    exp_t x;
    x.rdata = d;
    x.err   = e;
    x.rid   = id;
    sb.push_back(x);
  endtask

  function automatic logic [2:0] reqv();
    return {mreq[2].req, mreq[1].req, mreq[0].req};
  endfunction

  // Upstream responses must arrive in the order they were accepted.
  always @(negedge clk) begin
    if (rst_n && rsp.rvalid) begin
      chk("rsp_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0)
        chk("rsp_data", {rsp.r.rdata, rsp.r.err, rsp.r.rid},
            sb.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1);
  end

  initial begin
    tab[0] = '{1'b1, 2'd0, 1'b1, 3'b001, 3'b001, 1'b1};
    tab[1] = '{1'b1, 2'd1, 1'b1, 3'b000, 3'b010, 1'b0};
    tab[2] = '{1'b1, 2'd2, 1'b1, 3'b100, 3'b100, 1'b1};
    tab[3] = '{1'b1, 2'd3, 1'b1, 3'b111, 3'b000, 1'b1};
    tab[4] = '{1'b0, 2'd1, 1'b1, 3'b010, 3'b000, 1'b1};
    tab[5] = '{1'b1, 2'd2, 1'b0, 3'b100, 3'b000, 1'b1};
    tab[6] = '{1'b1, 2'd1, 1'b1, 3'b101, 3'b010, 1'b0};

    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    at_neg();
    chk("rst_busy", busy, 0);
    chk("rst_irq", irq, 0);
    chk("rst_stray", stray, 0);
    chk("rst_req", reqv(), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // routing table: request dropped before the edge, never accepted
    for (int i = 0; i < 7; i++) begin
      idle();
      dec_valid  = tab[i].dv;
      sel        = tab[i].sel;
      req.req    = tab[i].rq;
      req.a.addr = 32'hA000_0000 + i;
      for (int k = 0; k < N; k++) mrsp[k].gnt = tab[i].dg[k];
      #3;
      chk($sformatf("tab%0d_req", i), reqv(), tab[i].ereq);
      chk($sformatf("tab%0d_gnt", i), rsp.gnt, tab[i].egnt);
      chk($sformatf("tab%0d_bcast", i), mreq[2].a.addr,
          32'hA000_0000 + i);
      idle();
      step();
    end

    // single read to port 1
    idle(); rd(1, 1, 1); mrsp[1].gnt = 1'b1;
    at_neg();
    chk("t1_gnt", rsp.gnt, 1);
    chk("t1_busy0", busy, 0);
    push(32'h1234, 0, 1);
    step();
    idle(); rv(1, 32'h1234, 1);
    at_neg();
    chk("t1_busy1", busy, 1);
    step();
    idle();
    at_neg();
    chk("t1_busy2", busy, 0);
    step();

    // fill to NumMaxTrans, then stall; then switch target
    idle(); rd(1, 0, 0); mrsp[0].gnt = 1'b1;
    at_neg(); chk("t2_gnt_a", rsp.gnt, 1);
    push(32'h100, 0, 0);
    step();
    idle(); rd(1, 0, 1); mrsp[0].gnt = 1'b1;
    at_neg(); chk("t2_gnt_b", rsp.gnt, 1);
    push(32'h101, 0, 1);
    step();
    idle(); rd(1, 0, 2); mrsp[0].gnt = 1'b1;
    at_neg();
    chk("t2_full_gnt", rsp.gnt, 0);
    chk("t2_full_req", mreq[0].req, 0);
    step();
    idle(); rd(1, 0, 2); mrsp[0].gnt = 1'b1;
    rv(0, 32'h100, 0);
    at_neg(); chk("t2_rsp_cyc_gnt", rsp.gnt, 0);
    step();
    idle(); rd(1, 0, 2); mrsp[0].gnt = 1'b1;
    at_neg(); chk("t2_gnt_c", rsp.gnt, 1);
    push(32'h102, 0, 2);
    step();
    idle(); rd(1, 2, 3); mrsp[2].gnt = 1'b1;
    rv(0, 32'h101, 1);
    at_neg(); chk("t2_switch_a", rsp.gnt, 0);
    step();
    idle(); rd(1, 2, 3); mrsp[2].gnt = 1'b1;
    rv(0, 32'h102, 2);
    at_neg(); chk("t2_switch_b", rsp.gnt, 0);
    step();
    idle(); rd(1, 2, 3); mrsp[2].gnt = 1'b1;
    at_neg(); chk("t2_switch_gnt", rsp.gnt, 1);
    push(32'h203, 0, 3);
    step();
    idle(); rv(2, 32'h203, 3);
    step();
    idle();
    at_neg();
    chk("t2_busy", busy, 0);
    chk("t2_stray", stray, 0);
    step();

    // decode errors, back to back
    idle(); rd(0, 1, 3);
    at_neg();
    chk("t3_gnt_a", rsp.gnt, 1);
    chk("t3_noroute", reqv(), 0);
    chk("t3_irq0", irq, 0);
    push(32'hBADCAB1E, 1, 3);
    step();
    idle(); rd(0, 0, 5);
    at_neg();
    chk("t3_gnt_b", rsp.gnt, 1);
    chk("t3_irq_a", irq, 1);
    push(32'hBADCAB1E, 1, 5);
    step();
    idle();
    at_neg(); chk("t3_irq_b", irq, 1);
    step();
    at_neg();
    chk("t3_irq_end", irq, 0);
    chk("t3_busy", busy, 0);
    step();

    // accept and response in the same cycle
    idle(); rd(1, 1, 1); mrsp[1].gnt = 1'b1;
    at_neg(); chk("t4_gnt_a", rsp.gnt, 1);
    push(32'h301, 0, 1);
    step();
    idle(); rd(1, 1, 2); mrsp[1].gnt = 1'b1;
    rv(1, 32'h301, 1);
    at_neg(); chk("t4_gnt_b", rsp.gnt, 1);
    push(32'h302, 0, 2);
    step();
    idle(); rv(1, 32'h302, 2);
    at_neg(); chk("t4_busy1", busy, 1);
    step();
    idle();
    at_neg(); chk("t4_busy0", busy, 0);
    step();

    // stray responses and sticky clear
    idle(); rd(1, 0, 4); mrsp[0].gnt = 1'b1;
    at_neg(); chk("t5_gnt", rsp.gnt, 1);
    push(32'h404, 0, 4);
    step();
    idle(); rv(2, 32'hDEAD, 7);
    at_neg(); chk("t5_stray0", stray, 0);
    step();
    idle();
    at_neg();
    chk("t5_stray1", stray, 1);
    chk("t5_busy", busy, 1);
    step();
    idle(); rv(0, 32'h404, 4);
    step();
    idle(); clr = 1'b1;
    at_neg(); chk("t5_busy0", busy, 0);
    step();
    idle(); clr = 1'b1; rv(2, 32'hDEAD, 7);
    at_neg(); chk("t5_cleared", stray, 0);
    step();
    idle();
    at_neg(); chk("t5_set_wins", stray, 1);
    clr = 1'b1;
    step();
    idle(); rv(0, 32'hBEEF, 0);
    at_neg(); chk("t5_clr2", stray, 0);
    step();
    idle();
    at_neg(); chk("t5_idle_rsp", stray, 1);
    clr = 1'b1;
    step();
    idle();

    // reset with a transaction in flight
    rd(1, 1, 6); mrsp[1].gnt = 1'b1;
    at_neg(); chk("t6_gnt", rsp.gnt, 1);
    step();
    idle(); rst_n = 1'b0;
    at_neg();
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_stray", stray, 0);
    step();
    rst_n = 1'b1;
    step();
    rv(1, 32'h606, 6);
    step();
    idle();
    at_neg(); chk("t6_late_stray", stray, 1);
    clr = 1'b1;
    step();
    idle();

`ifdef USER_OBI_DEMUX_TIMEOUT_EN
    // hung subordinate: watchdog drains with error beats
    rd(1, 1, 4); mrsp[1].gnt = 1'b1;
    at_neg(); chk("t7_gnt_a", rsp.gnt, 1);
    push(32'hBADCAB1E, 1, 5);
    step();
    idle(); rd(1, 1, 5); mrsp[1].gnt = 1'b1;
    at_neg(); chk("t7_gnt_b", rsp.gnt, 1);
    push(32'hBADCAB1E, 1, 5);
    step();
    idle();
    for (int k = 0; k < 60; k++) begin
      if (!busy) break;
      step();
    end
    chk("t7_drained", busy, 0);
    chk("t7_timeout", to, 1);
    rv(1, 32'h777, 4);
    step();
    idle();
    at_neg(); chk("t7_drop_nostray", stray, 0);
    step();
`endif

    idle();
    step();
    step();
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
